// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern generator: the pattern-select codes
// and the bounce direction.
// No ports.
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage : led_pkg

// File: rtl/led_prescaler.sv
// ---------------------------------------------------------------------------
// led_prescaler
// Programmable tick generator. The counter runs 0..period_r and produces a
// one-cycle step every period_r+1 enabled cycles. Loading a new period or
// clearing (on a pattern mode change) restarts the count and suppresses the
// step for that cycle.
//
// Ports:
//   CLK     in   clock
//   RST     in   synchronous active-high reset
//   en      in   1 = count, 0 = hold count and period
//   clear   in   restart count (mode change), highest priority after RST
//   load    in   latch period and restart count
//   period  in   [CNT_WIDTH] new period value
//   step    out  combinational: pattern advances at the coming edge
//   tick    out  registered copy of step, aligned with the pattern update
// ---------------------------------------------------------------------------
module led_prescaler #(
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned DEFAULT_PERIOD = 1023
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 step,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] period_r;
    logic                 at_terminal;

    assign at_terminal = (count == period_r);
    // A clear or load owns the cycle: no step even if the count is terminal.
    assign step = en && !clear && !load && at_terminal;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count    <= '0;
            period_r <= CNT_WIDTH'(DEFAULT_PERIOD);
            tick     <= 1'b0;
        end else begin
            tick <= step;
            if (clear || load) begin
                count <= '0;
                if (load) begin
                    period_r <= period;
                end
            end else if (en) begin
                count <= at_terminal ? '0 : count + CNT_WIDTH'(1);
            end
        end
    end

endmodule : led_prescaler

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Board LED driver: a prescaled tick steps one of four display patterns
// (binary, walking one, bounce, Gray) and a free-running PWM gate applies
// global brightness before the registered LED output.
//
// Bounce direction:
//   dir      | meaning
//   DIR_UP   | pos increments toward WIDTH-1
//   DIR_DOWN | pos decrements toward 0
//
// Ports:
//   CLK          in   clock
//   RST          in   synchronous active-high reset
//   EN           in   1 = prescaler and pattern run, 0 = freeze (PWM runs)
//   MODE         in   [2] pattern select (0 bin, 1 walk, 2 bounce, 3 gray)
//   PERIOD       in   [CNT_WIDTH] new prescaler period
//   PERIOD_LOAD  in   latch PERIOD this cycle
//   DUTY         in   [PWM_BITS] brightness; all-ones = fully on, 0 = off
//   LED          out  [WIDTH] registered LED drive
//   TICK         out  registered one-cycle pulse per pattern step
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned DEFAULT_PERIOD = 1023,
    parameter int          PWM_BITS       = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [1:0]           MODE,
    input  logic [CNT_WIDTH-1:0] PERIOD,
    input  logic                 PERIOD_LOAD,
    input  logic [PWM_BITS-1:0]  DUTY,
    output logic [WIDTH-1:0]     LED,
    output logic                 TICK
);

    localparam int               POS_W   = $clog2(WIDTH);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

    mode_e                mode_r;
    logic [WIDTH-1:0]     bin;
    logic [POS_W-1:0]     pos;
    dir_e                 dir;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [WIDTH-1:0]     pat;
    logic                 gate;
    logic                 mode_change;
    logic                 step;

    assign mode_change = (MODE != mode_r);

    led_prescaler #(
        .CNT_WIDTH      (CNT_WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_prescaler (
        .CLK    (CLK),
        .RST    (RST),
        .en     (EN),
        .clear  (mode_change),
        .load   (PERIOD_LOAD),
        .period (PERIOD),
        .step   (step),
        .tick   (TICK)
    );

    always_comb begin
        pat = '0;
        case (mode_r)
            MODE_BIN:  pat = bin;
            MODE_GRAY: pat = bin ^ (bin >> 1);
            default:   pat = WIDTH'(1) << pos;
        endcase
    end

    // The strict compare can never reach all-ones, so that code is forced on.
    assign gate = (DUTY == '1) || (pwm_cnt < DUTY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_r  <= MODE_BIN;
            bin     <= '0;
            pos     <= '0;
            dir     <= DIR_UP;
            pwm_cnt <= '0;
            LED     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            LED     <= pat & {WIDTH{gate}};
            if (mode_change) begin
                mode_r <= mode_e'(MODE);
                bin    <= '0;
                pos    <= '0;
                dir    <= DIR_UP;
            end else if (step) begin
                case (mode_r)
                    MODE_BIN, MODE_GRAY: begin
                        bin <= bin + WIDTH'(1);
                    end
                    MODE_WALK: begin
                        pos <= (pos == POS_MAX) ? '0 : pos + POS_W'(1);
                    end
                    MODE_BOUNCE: begin
                        // Reversal moves off the end in the same step so the
                        // end positions are never shown twice.
                        if (dir == DIR_UP) begin
                            if (pos == POS_MAX) begin
                                dir <= DIR_DOWN;
                                pos <= pos - POS_W'(1);
                            end else begin
                                pos <= pos + POS_W'(1);
                            end
                        end else begin
                            if (pos == '0) begin
                                dir <= DIR_UP;
                                pos <= pos + POS_W'(1);
                            end else begin
                                pos <= pos - POS_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen: behavioural model checked every cycle plus
// directed literal expectations.
module tb_led_pattern_gen;

    localparam int W  = 8;
    localparam int CW = 32;
    localparam int DP = 3;
    localparam int PB = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          EN = 1'b0;
    logic [1:0]    MODE = 2'd0;
    logic [CW-1:0] PERIOD = '0;
    logic          PERIOD_LOAD = 1'b0;
    logic [PB-1:0] DUTY = 4'hF;
    logic [W-1:0]  LED;
    logic          TICK;

    int n_pass = 0;
    int n_total = 0;

    led_pattern_gen #(
        .WIDTH          (W),
        .CNT_WIDTH      (CW),
        .DEFAULT_PERIOD (DP),
        .PWM_BITS       (PB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .MODE        (MODE),
        .PERIOD      (PERIOD),
        .PERIOD_LOAD (PERIOD_LOAD),
        .DUTY        (DUTY),
        .LED         (LED),
        .TICK        (TICK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Pattern after k steps since the last (re)initialisation.
    function automatic logic [7:0] model_pat(input int mode, input int k);
        int b, p;
        b = k % 256;
        case (mode)
            0: return 8'(b);
            1: return 8'(1 << (k % W));
            2: begin
                p = k % (2 * W - 2);
                if (p >= W) p = 2 * W - 2 - p;
                return 8'(1 << p);
            end
            default: return 8'(b ^ (b >> 1));
        endcase
    endfunction

    bit         started = 0;
    int         m_period, m_count, m_mode, m_k, m_pwm;
    logic [7:0] m_led;
    logic       m_tick;

    always @(posedge CLK) begin
        if (RST) begin
            started  <= 1;
            m_period <= DP;
            m_count  <= 0;
            m_mode   <= 0;
            m_k      <= 0;
            m_pwm    <= 0;
            m_led    <= 8'h00;
            m_tick   <= 1'b0;
        end else begin
            m_led  <= ((DUTY == 4'hF) || (m_pwm < int'(DUTY))) ? model_pat(m_mode, m_k) : 8'h00;
            m_pwm  <= (m_pwm + 1) % 16;
            m_tick <= 1'b0;
            if (int'(MODE) != m_mode) begin
                m_mode  <= int'(MODE);
                m_k     <= 0;
                m_count <= 0;
                if (PERIOD_LOAD) m_period <= int'(PERIOD);
            end else if (PERIOD_LOAD) begin
                m_period <= int'(PERIOD);
                m_count  <= 0;
            end else if (EN) begin
                if (m_count == m_period) begin
                    m_count <= 0;
                    m_k     <= m_k + 1;
                    m_tick  <= 1'b1;
                end else begin
                    m_count <= m_count + 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            check("led_model", 32'(LED), 32'(m_led));
            check("tick_model", 32'(TICK), 32'(m_tick));
        end
    end

    // ---------------- directed helpers ----------------
    // Wait for the next TICK, then one more cycle so LED shows the new step.
    task automatic next_step();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!TICK && n < 100);
        check("tick_seen", 32'(TICK), 32'd1);
        @(negedge CLK);
    endtask

    task automatic tick_gap(output int gap);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!TICK && n < 100);
        gap = 0;
        do begin
            @(negedge CLK);
            gap++;
        end while (!TICK && gap < 100);
    endtask

    logic [7:0] walk_exp   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] gray_exp   [7]  = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, on_cnt, falls, ticks;
        logic prev_on;

        // model pins
        check("pin_bin_wrap", 32'(model_pat(0, 256)), 32'h00);
        check("pin_bounce_top", 32'(model_pat(2, 8)), 32'h40);
        check("pin_gray4", 32'(model_pat(3, 4)), 32'h06);

        // reset
        repeat (3) @(negedge CLK);
        check("reset_led", 32'(LED), 32'h00);
        check("reset_tick", 32'(TICK), 32'd0);

        // 1. bin mode
        RST = 1'b0; EN = 1'b1; MODE = 2'd0; DUTY = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            next_step();
            check("bin_step", 32'(LED), 32'(i));
        end
        tick_gap(gap);
        check("bin_tick_interval", 32'(gap), 32'd4);
        for (int i = 0; i < 250; i++) next_step();
        check("bin_ff", 32'(LED), 32'hFF);
        next_step();
        check("bin_wrap", 32'(LED), 32'h00);

        // 2. walk mode
        MODE = 2'd1;
        repeat (2) @(negedge CLK);
        check("walk_start", 32'(LED), 32'h01);
        for (int i = 0; i < 8; i++) begin
            next_step();
            check("walk_step", 32'(LED), 32'(walk_exp[i]));
        end

        // 3. bounce and gray
        MODE = 2'd2;
        repeat (2) @(negedge CLK);
        check("bounce_start", 32'(LED), 32'h01);
        for (int i = 0; i < 15; i++) begin
            next_step();
            check("bounce_step", 32'(LED), 32'(bounce_exp[i]));
        end
        MODE = 2'd3;
        repeat (2) @(negedge CLK);
        check("gray_start", 32'(LED), 32'h00);
        for (int i = 0; i < 7; i++) begin
            next_step();
            check("gray_step", 32'(LED), 32'(gray_exp[i]));
        end

        // 4. period load at count == 2, then ticks every cycle
        @(negedge CLK);
        PERIOD = 32'd0; PERIOD_LOAD = 1'b1;
        @(negedge CLK);
        check("load_no_tick", 32'(TICK), 32'd0);
        PERIOD_LOAD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("period0_tick", 32'(TICK), 32'd1);
        end
        PERIOD_LOAD = 1'b1;
        @(negedge CLK);
        check("load_blocks_tick", 32'(TICK), 32'd0);
        PERIOD_LOAD = 1'b0;

        // EN freeze: restart bin, let it reach 2, then hold
        MODE = 2'd0;
        repeat (3) @(negedge CLK);
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("en0_tick", 32'(TICK), 32'd0);
            check("en0_hold", 32'(LED), 32'h02);
        end
        EN = 1'b1;
        @(negedge CLK);
        check("en1_tick", 32'(TICK), 32'd1);
        check("en1_led_lag", 32'(LED), 32'h02);
        @(negedge CLK);
        check("en1_resume", 32'(LED), 32'h03);

        // 5. brightness: frozen walk at 0x01 with DUTY=4
        EN = 1'b0; MODE = 2'd1; DUTY = 4'd4;
        repeat (2) @(negedge CLK);
        on_cnt = 0; falls = 0; prev_on = (LED != 8'h00);
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            if (LED != 8'h00) on_cnt++;
            if (prev_on && LED == 8'h00) falls++;
            prev_on = (LED != 8'h00);
            if (i == 15) check("duty4_window1", 32'(on_cnt), 32'd4);
        end
        check("duty4_total", 32'(on_cnt), 32'd8);
        check("duty4_runs", 32'(falls), 32'd2);

        EN = 1'b1; DUTY = 4'd0;
        @(negedge CLK);
        on_cnt = 0; ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (LED != 8'h00) on_cnt++;
            if (TICK) ticks++;
        end
        check("duty0_dark", 32'(on_cnt), 32'd0);
        check("duty0_ticks", 32'(ticks), 32'd20);
        DUTY = 4'hF;
        repeat (3) @(negedge CLK);

        // 6. reset mid-bounce with period 7
        MODE = 2'd2; PERIOD = 32'd7; PERIOD_LOAD = 1'b1;
        @(negedge CLK);
        PERIOD_LOAD = 1'b0;
        for (int i = 0; i < 3; i++) next_step();
        check("bounce_p7", 32'(LED), 32'h08);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_led", 32'(LED), 32'h00);
        check("midrst_tick", 32'(TICK), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_restart", 32'(LED), 32'h01);
        tick_gap(gap);
        check("rst_period", 32'(gap), 32'd4);

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_led_pattern_gen

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised successor to the fixed 8-bit board LED counter. It contains a programmable prescaler that generates a periodic tick. Four selectable display patterns advance on that tick: binary count, walking one, bounce, and Gray count. A free-running PWM gate applies global brightness to the pattern. It sits at the top level of board demos and drives the LED pins directly; control inputs come from switches or a register block.

## Interface
Parameters:
- WIDTH, 8, number of LEDs (≥2)
- CNT_WIDTH, 32, prescaler counter/period width
- DEFAULT_PERIOD, 1023, period value loaded at reset
- PWM_BITS, 4, brightness resolution

Ports:
- CLK  input  1  clock
- RST  input  1  reset, synchronous, active-high
- EN  input  1  1 = prescaler and pattern run; 0 = freeze
- MODE  input  2  pattern select (0 bin, 1 walk, 2 bounce, 3 gray)
- PERIOD  input  CNT_WIDTH  new prescaler period
- PERIOD_LOAD  input  1  latch PERIOD this cycle
- DUTY  input  PWM_BITS  brightness
- LED  output  WIDTH  registered LED drive
- TICK  output  1  registered one-cycle pulse per pattern step

## Operation
- **Prescaler.** Register `count` runs 0..`period_r` when EN=1.
  - When `count == period_r`: next edge sets `count` to 0, advances the pattern, and sets TICK=1.
  - Tick interval is `period_r+1` cycles. `period_r = 0` gives a tick every cycle.
- **Period load.** PERIOD_LOAD=1 latches PERIOD into `period_r` and clears `count`. No tick or pattern step occurs that cycle, regardless of EN.
- **Mode change.** Register `mode_r` holds the active mode. When MODE ≠ `mode_r`:
  - `mode_r` ← MODE.
  - Pattern state is reinitialised (bin=0, pos=0, dir=up).
  - `count` is cleared.
  - No tick occurs that cycle.
  - If PERIOD_LOAD is also 1, the period is latched in the same cycle.
- **Priority.** RST > mode change > PERIOD_LOAD > tick step.
- **EN=0.** `count`, pattern state and `period_r` hold; TICK=0. PWM keeps running, so LED still shows the frozen pattern, gated by PWM. Loads and mode changes still take effect.
- **Patterns** (`pat`, WIDTH bits):
  - **bin:** `pat = bin`. `bin` increments modulo 2^WIDTH.
  - **walk:** `pat = 1<<pos`. `pos` goes 0..WIDTH-1, then wraps to 0.
  - **bounce:** `pat = 1<<pos`. `pos` counts up to WIDTH-1, reverses, counts down to 0, reverses. End positions are not repeated: 0,1,…,W-1,W-2,…,1,0,1,…
  - **gray:** `pat = bin ^ (bin>>1)`. `bin` increments as in bin mode.
- **PWM.** `pwm_cnt` (PWM_BITS wide) increments every cycle, free-running and independent of EN.
  - Gate is on when `pwm_cnt < DUTY`.
  - DUTY = all-ones forces the gate permanently on.
  - DUTY = 0 forces LED = 0.
- **Output.** LED ← `pat & {WIDTH{gate}}` every cycle.

## Timing
- **Reset values:**
  - `count` = 0, `period_r` = DEFAULT_PERIOD, `mode_r` = 0.
  - bin = 0, pos = 0, dir = up, `pwm_cnt` = 0.
  - LED = 0, TICK = 0.
- RST in mid-operation aborts everything. The next cycle starts from the reset values.
- **Tick latency:** TICK and the updated pattern state appear on the same edge, the one after the cycle in which `count == period_r`.
- **LED latency:** LED reflects pattern state and `pwm_cnt` one cycle later.
- A mode change is visible on LED two edges after MODE changes.
- PERIOD_LOAD takes effect at the next edge. The first tick after a load arrives `new_period+1` cycles later.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **Shared package `led_pkg`:**
  - MODE_BIN = 2'd0, MODE_WALK = 2'd1, MODE_BOUNCE = 2'd2, MODE_GRAY = 2'd3.
  - Direction constants DIR_UP / DIR_DOWN.
- **Sub-module `led_prescaler`** (CNT_WIDTH parameter). It holds `count`, `period_r`, load/clear handling, and the tick strobe. The top level instantiates it and holds the pattern state, PWM, and output register.

## Test plan
Common settings: WIDTH=8, DEFAULT_PERIOD=3, DUTY=4'hF (always on) unless stated.
1. **Bin mode.** Release RST with MODE=0, EN=1 → TICK every 4 cycles; LED steps 0x00, 0x01, 0x02, …, 0xFF, then wraps to 0x00 after 256 ticks.
2. **Walk mode.** MODE=1 → LED steps 0x01, 0x02, 0x04, …, 0x80, 0x01. Each mode switch restarts the pattern at 0x01.
3. **Bounce and Gray modes.**
   - MODE=2 → LED 0x01, 0x02, …, 0x80, 0x40, …, 0x01, 0x02 (no doubled 0x80 or 0x01).
   - MODE=3 → LED 0x00, 0x01, 0x03, 0x02, 0x06, 0x07, 0x05, 0x04.
4. **Period load and EN.**
   - PERIOD_LOAD with PERIOD=0 while `count` = 2 → no tick that cycle, then TICK every cycle.
   - EN=0 for 10 cycles → TICK=0 and the LED pattern holds; EN=1 resumes stepping from the held state.
5. **Brightness.**
   - DUTY=4 → in every 16-cycle window each lit LED is high exactly 4 consecutive cycles.
   - DUTY=0 → LED stays 0x00 while pattern state keeps advancing.
6. **Reset mid-run.** RST asserted mid-bounce with `period_r` loaded to 7 → next cycle LED=0x00, TICK=0, `period_r`=3. Re-entering MODE=2 restarts at 0x01.
